// File: rtl/i2c_fifo_pkg.sv
// ============================================================================
// i2c_fifo_pkg: shared constants and skid-buffer state encoding for the I2C FIFO.
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_SIZE  = 4;
  localparam int DEF_STAT_WIDTH = 16;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_fifo_skid_buffer.sv
// ============================================================================
// i2c_fifo_skid_buffer: 2-entry in-order buffer with registered ready.
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_fifo_skid_buffer
  import i2c_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  write_clock_i,
  input  logic                  write_reset_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  not_empty_o,
  output logic                  ready_o
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push_i) begin
            head_d  = push_data_i;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({push_i, pop_i})
            2'b11: head_d = push_data_i;
            2'b10: begin
              tail_d  = push_data_i;
              state_d = BUF_TWO;
            end
            2'b01: state_d = BUF_EMPTY;
            default: state_d = BUF_ONE;
          endcase
        end
        BUF_TWO: begin
          // ready is low in TWO, so a push here only ever pairs with a pop
          if (pop_i) begin
            head_d = tail_q;
            if (push_i) tail_d = push_data_i;
            else        state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
    ready_d = (state_d != BUF_TWO);
  end

  always_ff @(posedge write_clock_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end

  assign head_data_o = head_q;
  assign not_empty_o = (state_q != BUF_EMPTY);
  assign ready_o     = ready_q;

endmodule

`default_nettype wire

// File: rtl/i2c_fifo_write_ctrl.sv
// ============================================================================
// i2c_fifo_write_ctrl: write-domain front end feeding FIFO memory and write pointer.
// Define I2C_FIFO_WR_STATS_EN to build the accept/stall counters. Rev 1.0
// ============================================================================
`default_nettype none

module i2c_fifo_write_ctrl
  import i2c_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STAT_WIDTH = DEF_STAT_WIDTH
) (
  input  logic                  write_clock_i,
  input  logic                  write_reset_n_i,
  input  logic                  host_valid_i,
  input  logic [DATA_WIDTH-1:0] host_data_i,
  output logic                  host_ready_o,
  input  logic                  host_flush_i,
  input  logic                  write_full_i,
  input  logic                  write_almost_full_i,
  output logic                  write_inc_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  space_low_o,
  output logic [STAT_WIDTH-1:0] accept_count_o,
  output logic [STAT_WIDTH-1:0] stall_count_o
);

  logic w_accept;
  logic w_drain;
  logic w_not_empty;
  logic w_ready;

  assign w_accept = host_valid_i & w_ready & ~host_flush_i;
  assign w_drain  = w_not_empty & ~write_full_i & ~host_flush_i;

  i2c_fifo_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .write_clock_i   (write_clock_i),
    .write_reset_n_i (write_reset_n_i),
    .push_i          (w_accept),
    .push_data_i     (host_data_i),
    .pop_i           (w_drain),
    .flush_i         (host_flush_i),
    .head_data_o     (write_data_o),
    .not_empty_o     (w_not_empty),
    .ready_o         (w_ready)
  );

  assign host_ready_o = w_ready;
  assign write_inc_o  = w_drain;
  assign space_low_o  = write_almost_full_i | write_full_i;

`ifdef I2C_FIFO_WR_STATS_EN
  localparam logic [STAT_WIDTH-1:0] c_stat_one = 1;

  logic [STAT_WIDTH-1:0] accept_cnt_q;
  logic [STAT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge write_clock_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) begin
      accept_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (w_accept && (accept_cnt_q != '1))
        accept_cnt_q <= accept_cnt_q + c_stat_one;
      if (w_not_empty && write_full_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + c_stat_one;
    end
  end

  assign accept_count_o = accept_cnt_q;
  assign stall_count_o  = stall_cnt_q;
`else
  assign accept_count_o = '0;
  assign stall_count_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_fifo_write_ctrl.sv
// ============================================================================
// tb_i2c_fifo_write_ctrl: directed self-checking bench for i2c_fifo_write_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_fifo_write_ctrl;

  localparam int TB_STAT_W = 8;
  localparam int STAT_MAX  = (1 << TB_STAT_W) - 1;
`ifdef I2C_FIFO_WR_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic                 write_clock_i = 1'b0;
  logic                 write_reset_n_i = 1'b0;
  logic                 host_valid_i = 1'b0;
  logic [7:0]           host_data_i = 8'h00;
  logic                 host_ready_o;
  logic                 host_flush_i = 1'b0;
  logic                 write_full_i = 1'b0;
  logic                 write_almost_full_i = 1'b0;
  logic                 write_inc_o;
  logic [7:0]           write_data_o;
  logic                 space_low_o;
  logic [TB_STAT_W-1:0] accept_count_o;
  logic [TB_STAT_W-1:0] stall_count_o;

  i2c_fifo_write_ctrl #(
    .DATA_WIDTH (8),
    .STAT_WIDTH (TB_STAT_W)
  ) dut (
    .write_clock_i       (write_clock_i),
    .write_reset_n_i     (write_reset_n_i),
    .host_valid_i        (host_valid_i),
    .host_data_i         (host_data_i),
    .host_ready_o        (host_ready_o),
    .host_flush_i        (host_flush_i),
    .write_full_i        (write_full_i),
    .write_almost_full_i (write_almost_full_i),
    .write_inc_o         (write_inc_o),
    .write_data_o        (write_data_o),
    .space_low_o         (space_low_o),
    .accept_count_o      (accept_count_o),
    .stall_count_o       (stall_count_o)
  );

  always #5 write_clock_i = ~write_clock_i;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] m_q[$];
  logic       m_ready  = 1'b0;
  int         m_acc    = 0;
  int         m_stall  = 0;
  int         n_pop    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_stat(input int v);
    return (STATS_ON != 0) ? v : 0;
  endfunction

  // One clock cycle: apply inputs, compare against the reference model, advance.
  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic fl);
    logic acc;
    logic drn;
    host_valid_i = v;
    host_data_i  = d;
    write_full_i = f;
    host_flush_i = fl;
    #1;
    acc = v & m_ready & ~fl;
    drn = (m_q.size() != 0) & ~f & ~fl;
    check("ready", host_ready_o, m_ready);
    check("inc", write_inc_o, drn);
    if (drn) check("data", write_data_o, m_q[0]);
    check("acc_cnt", accept_count_o, exp_stat(m_acc));
    check("stall_cnt", stall_count_o, exp_stat(m_stall));
    if ((m_q.size() != 0) && f && (m_stall < STAT_MAX)) m_stall++;
    if (fl) begin
      m_q.delete();
    end else begin
      if (drn) begin
        void'(m_q.pop_front());
        n_pop++;
      end
      if (acc) begin
        m_q.push_back(d);
        if (m_acc < STAT_MAX) m_acc++;
      end
    end
    m_ready = (m_q.size() < 2);
    @(posedge write_clock_i);
    #1;
  endtask

  initial begin
    int idx;
    int cyc;
    int p0;

    // reset state
    #2;
    check("rst_ready", host_ready_o, 0);
    check("rst_inc", write_inc_o, 0);
    check("rst_data", write_data_o, 0);
    check("rst_acc", accept_count_o, 0);
    write_almost_full_i = 1'b1;
    #1;
    check("space_low_af", space_low_o, 1);
    write_almost_full_i = 1'b0;
    #1;
    check("space_low_0", space_low_o, 0);
    @(posedge write_clock_i);
    @(posedge write_clock_i);
    #1;
    write_reset_n_i = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("s1_ready_up", host_ready_o, 1);

    // back-to-back stream with FIFO not full
    step(1'b1, 8'h11, 1'b0, 1'b0);
    check("s1_inc0", write_inc_o, 1);
    check("s1_d0", write_data_o, 8'h11);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    check("s1_d1", write_data_o, 8'h22);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check("s1_d2", write_data_o, 8'h33);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("s1_idle_inc", write_inc_o, 0);
    check("s1_acc", accept_count_o, exp_stat(3));

    // stall on full, then release
    step(1'b1, 8'hA0, 1'b1, 1'b0);
    step(1'b1, 8'hA1, 1'b1, 1'b0);
    check("s2_ready_low", host_ready_o, 0);
    check("s2_no_inc", write_inc_o, 0);
    step(1'b1, 8'hA2, 1'b1, 1'b0);
    step(1'b1, 8'hA2, 1'b1, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    check("s2_head_a1", write_data_o, 8'hA1);
    check("s2_ready_up", host_ready_o, 1);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    check("s2_head_a2", write_data_o, 8'hA2);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("s2_empty", write_inc_o, 0);
    check("s2_stall", stall_count_o, exp_stat(3));
    check("s2_acc", accept_count_o, exp_stat(6));

    // 16-word stream, full toggling every cycle once the buffer holds two
    idx = 0;
    cyc = 0;
    p0  = n_pop;
    while (!((idx == 16) && (m_q.size() == 0)) && (cyc < 100)) begin
      logic f;
      logic take;
      f = (cyc < 2) || (cyc % 2 == 1);
      take = (idx < 16) && m_ready;
      step(idx < 16, 8'hC0 + idx[7:0], f, 1'b0);
      if (take) idx++;
      cyc++;
    end
    check("s3_done", (idx == 16) && (m_q.size() == 0), 1);
    check("s3_pops", n_pop - p0, 16);

    // flush while holding one word
    step(1'b1, 8'h44, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("fl_ready", host_ready_o, 1);
    check("fl_no_push", write_inc_o, 0);
    check("fl_acc", accept_count_o, exp_stat(22 + 1));

    // asynchronous reset while holding two words
    step(1'b1, 8'hE0, 1'b1, 1'b0);
    step(1'b1, 8'hE1, 1'b1, 1'b0);
    check("mr_two", host_ready_o, 0);
    #3;
    write_reset_n_i = 1'b0;
    #1;
    check("mr_ready", host_ready_o, 0);
    check("mr_inc", write_inc_o, 0);
    check("mr_data", write_data_o, 0);
    check("mr_acc", accept_count_o, 0);
    check("mr_stall", stall_count_o, 0);
    m_q.delete();
    m_ready = 1'b0;
    m_acc   = 0;
    m_stall = 0;
    @(posedge write_clock_i);
    #1;
    host_valid_i    = 1'b0;
    write_full_i    = 1'b0;
    write_reset_n_i = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // saturation of the accept counter
    for (int i = 0; i < STAT_MAX + 1 + 5; i++) step(1'b1, i[7:0], 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("sat_acc", accept_count_o, exp_stat(STAT_MAX));
    check("sat_stall", stall_count_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
